// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single shared word memory.
// Each grant runs IDLE -> ACCESS -> RESP; ties go round-robin or to m0.
module mem_arbiter #(
   parameter int RR = 1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] m0_addr,
   input  logic        m0_rstrb,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wmask,
   output logic [31:0] m0_rdata,
   output logic        m0_ready,
   input  logic [31:0] m1_addr,
   input  logic        m1_rstrb,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wmask,
   output logic [31:0] m1_rdata,
   output logic        m1_ready,
   output logic        busy,
   output logic [31:0] mem_addr,
   output logic        mem_rstrb,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic        req0;
   logic        req1;
   logic        win;
   logic        grant;
   logic        last_grant;
   logic [31:0] l_addr;
   logic [31:0] l_wdata;
   logic [3:0]  l_wmask;
   logic        l_rstrb;

   assign req0 = m0_rstrb | (|m0_wmask);
   assign req1 = m1_rstrb | (|m1_wmask);

   // m1 wins when alone, or on a round-robin tie after m0 went last
   assign win = req1 & (~req0 | ((RR != 0) & ~last_grant));

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (req0 | req1) state_nxt = ACCESS;
         ACCESS:  state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         grant      <= 1'b0;
         last_grant <= 1'b1;
         l_addr     <= '0;
         l_wdata    <= '0;
         l_wmask    <= '0;
         l_rstrb    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && (req0 | req1)) begin
            grant      <= win;
            last_grant <= win;
            l_addr     <= win ? m1_addr  : m0_addr;
            l_wdata    <= win ? m1_wdata : m0_wdata;
            l_wmask    <= win ? m1_wmask : m0_wmask;
            l_rstrb    <= win ? m1_rstrb : m0_rstrb;
         end
      end
   end

   // latched fields only change on a grant, so they hold outside ACCESS
   assign mem_addr  = l_addr;
   assign mem_wdata = l_wdata;
   assign mem_wmask = (state == ACCESS) ? l_wmask : 4'b0000;
   assign mem_rstrb = (state == ACCESS) & l_rstrb & (l_wmask == 4'b0000);

   assign busy     = (state != IDLE);
   assign m0_ready = (state == RESP) & ~grant;
   assign m1_ready = (state == RESP) & grant;
   assign m0_rdata = mem_rdata;
   assign m1_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one round-robin and one fixed-priority
// instance share stimulus, each backed by its own word memory model.
module tb_mem_arbiter;

   logic        clk;
   logic        resetn;
   logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
   logic        m0_rstrb, m1_rstrb;
   logic [3:0]  m0_wmask, m1_wmask;

   logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        m0_ready, m1_ready, busy, mem_rstrb;
   logic [3:0]  mem_wmask;

   logic [31:0] f_m0_rdata, f_m1_rdata, f_mem_addr, f_mem_wdata, f_mem_rdata;
   logic        f_m0_ready, f_m1_ready, f_busy, f_mem_rstrb;
   logic [3:0]  f_mem_wmask;

   logic [31:0] mem   [0:63];
   logic [31:0] f_mem [0:63];
   logic        ld_en;
   logic [5:0]  ld_idx;
   logic [31:0] ld_val;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_rd;

   mem_arbiter #(.RR(1)) dut (
      .clk(clk), .resetn(resetn),
      .m0_addr(m0_addr), .m0_rstrb(m0_rstrb), .m0_wdata(m0_wdata),
      .m0_wmask(m0_wmask), .m0_rdata(m0_rdata), .m0_ready(m0_ready),
      .m1_addr(m1_addr), .m1_rstrb(m1_rstrb), .m1_wdata(m1_wdata),
      .m1_wmask(m1_wmask), .m1_rdata(m1_rdata), .m1_ready(m1_ready),
      .busy(busy), .mem_addr(mem_addr), .mem_rstrb(mem_rstrb),
      .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
   );

   mem_arbiter #(.RR(0)) dut_fp (
      .clk(clk), .resetn(resetn),
      .m0_addr(m0_addr), .m0_rstrb(m0_rstrb), .m0_wdata(m0_wdata),
      .m0_wmask(m0_wmask), .m0_rdata(f_m0_rdata), .m0_ready(f_m0_ready),
      .m1_addr(m1_addr), .m1_rstrb(m1_rstrb), .m1_wdata(m1_wdata),
      .m1_wmask(m1_wmask), .m1_rdata(f_m1_rdata), .m1_ready(f_m1_ready),
      .busy(f_busy), .mem_addr(f_mem_addr), .mem_rstrb(f_mem_rstrb),
      .mem_wdata(f_mem_wdata), .mem_wmask(f_mem_wmask),
      .mem_rdata(f_mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ld_en) begin
         mem[ld_idx] <= ld_val;
      end else begin
         if (mem_rstrb) mem_rdata <= mem[mem_addr[7:2]];
         for (int b = 0; b < 4; b++)
            if (mem_wmask[b])
               mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
   end

   always @(posedge clk) begin
      if (ld_en) begin
         f_mem[ld_idx] <= ld_val;
      end else begin
         if (f_mem_rstrb) f_mem_rdata <= f_mem[f_mem_addr[7:2]];
         for (int b = 0; b < 4; b++)
            if (f_mem_wmask[b])
               f_mem[f_mem_addr[7:2]][8*b +: 8] <= f_mem_wdata[8*b +: 8];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [5:0] idx, input logic [31:0] val);
      ld_en  = 1'b1;
      ld_idx = idx;
      ld_val = val;
      tick();
      ld_en  = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn   = 1'b0;
      m0_addr  = '0; m0_rstrb = 1'b0; m0_wdata = '0; m0_wmask = '0;
      m1_addr  = '0; m1_rstrb = 1'b0; m1_wdata = '0; m1_wmask = '0;
      ld_en    = 1'b0; ld_idx = '0; ld_val = '0;
      #3;
      chk("rst_busy",      busy,      0);
      chk("rst_m0_ready",  m0_ready,  0);
      chk("rst_m1_ready",  m1_ready,  0);
      chk("rst_mem_rstrb", mem_rstrb, 0);
      chk("rst_mem_wmask", mem_wmask, 0);
      chk("rst_mem_addr",  mem_addr,  0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_fp_busy",   f_busy,    0);

      preload(6'd4,  32'hDEADBEEF);
      preload(6'd8,  32'h0000_0000);
      preload(6'd12, 32'h1111_1111);
      preload(6'd14, 32'h0000_0000);
      tick();
      resetn = 1'b1;
      tick();

      // single read by m0
      m0_addr = 32'h10; m0_rstrb = 1'b1;
      tick();
      chk("rd_busy",      busy,      1);
      chk("rd_mem_rstrb", mem_rstrb, 1);
      chk("rd_mem_addr",  mem_addr,  32'h10);
      chk("rd_mem_wmask", mem_wmask, 0);
      chk("rd_early_rdy", m0_ready,  0);
      tick();
      chk("rd_m0_ready",  m0_ready,  1);
      chk("rd_m0_rdata",  m0_rdata,  32'hDEADBEEF);
      chk("rd_m1_ready",  m1_ready,  0);
      chk("rd_rstrb_off", mem_rstrb, 0);
      m0_rstrb = 1'b0;
      tick();
      chk("rd_idle_busy", busy,      0);
      chk("rd_idle_rdy",  m0_ready,  0);
      chk("rd_addr_hold", mem_addr,  32'h10);

      // masked write by m1
      m1_addr = 32'h20; m1_wdata = 32'hA5A5A5A5; m1_wmask = 4'b0101;
      tick();
      chk("wr_mem_wmask", mem_wmask, 4'b0101);
      chk("wr_mem_rstrb", mem_rstrb, 0);
      chk("wr_mem_addr",  mem_addr,  32'h20);
      chk("wr_mem_wdata", mem_wdata, 32'hA5A5A5A5);
      tick();
      chk("wr_m1_ready",  m1_ready,  1);
      chk("wr_m0_ready",  m0_ready,  0);
      chk("wr_mem8",      mem[8],    32'h00A500A5);
      chk("wr_wmask_off", mem_wmask, 0);
      chk("wr_rstrb_off", mem_rstrb, 0);
      m1_wmask = 4'b0000;
      tick();
      chk("wr_m1_pulse",  m1_ready,  0);

      // both request continuously: RR alternates, fixed priority keeps m0
      m0_addr = 32'h10; m0_rstrb = 1'b1;
      m1_addr = 32'h20; m1_rstrb = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("rr_access_rdy", m0_ready | m1_ready, 0);
         tick();
         exp_rd = (i % 2 == 0) ? 32'hDEADBEEF : 32'h00A500A5;
         chk("rr_m0_ready", m0_ready,   (i % 2 == 0) ? 1 : 0);
         chk("rr_m1_ready", m1_ready,   (i % 2 == 1) ? 1 : 0);
         chk("rr_rdata",    m0_rdata,   exp_rd);
         chk("fp_m0_ready", f_m0_ready, 1);
         chk("fp_m1_ready", f_m1_ready, 0);
         chk("fp_rdata",    f_m0_rdata, 32'hDEADBEEF);
         tick();
         chk("rr_idle",     busy,       0);
      end
      m0_rstrb = 1'b0;
      tick();
      tick();
      chk("drop_rr_m1",  m1_ready,   1);
      chk("drop_fp_m1",  f_m1_ready, 1);
      chk("drop_fp_m0",  f_m0_ready, 0);
      chk("drop_fp_rd",  f_m1_rdata, 32'h00A500A5);
      m1_rstrb = 1'b0;
      tick();

      // read+write treated as write
      m0_addr = 32'h30; m0_rstrb = 1'b1; m0_wmask = 4'hF;
      m0_wdata = 32'hCAFEF00D;
      tick();
      chk("rw_mem_rstrb", mem_rstrb, 0);
      chk("rw_mem_wmask", mem_wmask, 4'hF);
      tick();
      chk("rw_m0_ready",  m0_ready,  1);
      chk("rw_mem12",     mem[12],   32'hCAFEF00D);
      m0_rstrb = 1'b0; m0_wmask = 4'h0;
      tick();

      // request dropped right after grant
      m0_addr = 32'h20; m0_rstrb = 1'b1;
      tick();
      m0_rstrb = 1'b0;
      chk("dg_mem_rstrb", mem_rstrb, 1);
      tick();
      chk("dg_m0_ready",  m0_ready,  1);
      chk("dg_m0_rdata",  m0_rdata,  32'h00A500A5);
      tick();
      chk("dg_idle_rdy",  m0_ready,  0);
      tick();
      chk("dg_once_rdy",  m0_ready,  0);
      chk("dg_once_busy", busy,      0);

      // reset during the access cycle of a write
      m1_addr = 32'h38; m1_wdata = 32'h12345678; m1_wmask = 4'hF;
      tick();
      chk("rm_wmask_on",  mem_wmask, 4'hF);
      #2;
      resetn = 1'b0;
      #1;
      chk("rm_wmask_off", mem_wmask, 0);
      chk("rm_busy",      busy,      0);
      chk("rm_m1_ready",  m1_ready,  0);
      m1_wmask = 4'h0;
      tick();
      chk("rm_no_ready",  m1_ready,  0);
      resetn = 1'b1;
      tick();
      chk("rm_idle",      busy,      0);
      m1_addr = 32'h10; m1_rstrb = 1'b1;
      tick();
      chk("rm_rd_rstrb",  mem_rstrb, 1);
      chk("rm_rd_addr",   mem_addr,  32'h10);
      tick();
      chk("rm_rd_ready",  m1_ready,  1);
      chk("rm_rd_rdata",  m1_rdata,  32'hDEADBEEF);
      chk("rm_rd_m0",     m0_ready,  0);
      m1_rstrb = 1'b0;
      tick();
      chk("rm_rd_done",   m1_ready,  0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
